axis_keep_packer: RTL and testbench
===================================

AXIS_KEEP_PACKER -- requirements
Module: axis_keep_packer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 32, stream data width in bits.
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, tkeep is treated as all-ones.
- KEEP_WIDTH, ((DATA_WIDTH+7)/8), byte lanes per beat (K).
- ID_ENABLE, 0, propagate tid; when 0, output is zero.
- ID_WIDTH, 8, tid width.
- DEST_ENABLE, 0, propagate tdest; when 0, output is zero.
- DEST_WIDTH, 8, tdest width.
- USER_ENABLE, 1, propagate tuser; when 0, output is zero.
- USER_WIDTH, 1, tuser width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic is rising-edge.
- rst, in, 1, asynchronous active-high reset.
- s_axis_tdata, in, DATA_WIDTH, input data.
- s_axis_tkeep, in, KEEP_WIDTH, input byte qualifiers; may be sparse.
- s_axis_tvalid, in, 1, input valid.
- s_axis_tready, out, 1, input ready.
- s_axis_tlast, in, 1, input end of frame.
- s_axis_tid, in, ID_WIDTH, input stream id.
- s_axis_tdest, in, DEST_WIDTH, input destination.
- s_axis_tuser, in, USER_WIDTH, input sideband.
- m_axis_tdata, out, DATA_WIDTH, output data.
- m_axis_tkeep, out, KEEP_WIDTH, output byte qualifiers.
- m_axis_tvalid, out, 1, output valid.
- m_axis_tready, in, 1, output ready.
- m_axis_tlast, out, 1, output end of frame.
- m_axis_tid, out, ID_WIDTH, output stream id.
- m_axis_tdest, out, DEST_WIDTH, output destination.
- m_axis_tuser, out, USER_WIDTH, output sideband.

REQ-003 DATA_WIDTH SHALL be divisible by KEEP_WIDTH; elaboration SHALL fail with $error otherwise.

Function
REQ-004 The block SHALL compact kept bytes of each accepted beat in lane order (lane 0 first) and append them after a residue of R bytes (0..K-1) held from prior beats of the same frame.

REQ-005 With n kept bytes and T=R+n:
- T>=K and no tlast: emit a full beat (tkeep all-ones) and set R=T-K.
- tlast and T<=K: emit T bytes with tkeep low-contiguous and tlast=1, then set R=0.
- tlast and T>K: emit a full beat (tlast=0), enter FLUSH holding T-K bytes.

REQ-006 In FLUSH, the next output beat SHALL carry the T-K held bytes with tlast=1, then the block SHALL return to ACCUM with R=0; s_axis_tready SHALL be 0 throughout FLUSH.

REQ-007 A non-last beat with n=0 SHALL be consumed without producing output.

REQ-008 A tlast beat with T=0 SHALL emit a single beat with tkeep=0 and tlast=1.

REQ-009 Every non-final output beat of a frame SHALL have tkeep all-ones.

REQ-010 The output register SHALL be updated one clock after the accepting edge (latency 1), and s_axis_tready SHALL equal (!m_axis_tvalid || m_axis_tready) && state!=FLUSH.

REQ-011 While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs SHALL hold stable.

REQ-012 m_axis_tid, m_axis_tdest and m_axis_tuser SHALL take the values of the input beat that completes the output beat; a FLUSH beat SHALL reuse the tlast input beat's values.

REQ-013 When KEEP_ENABLE=0, every beat SHALL be treated as full, so the block acts as a one-stage register slice; m_axis_tkeep SHALL then be all-ones.

Reset
REQ-014 Asserting rst SHALL immediately force m_axis_tvalid=0, R=0 and state=ACCUM, discarding any partial frame.

REQ-015 During reset, s_axis_tready SHALL be 0. After deassertion, s_axis_tready SHALL be 1 and the data, tkeep, tlast, tid, tdest and tuser registers SHALL read 0.

Structure
REQ-016 No shared package SHALL be used. K, lane width and the residue counter width ($clog2(K)+1) SHALL be local constants. The state SHALL be a two-value local enum (ACCUM, FLUSH).

REQ-017 Byte compaction (sparse tkeep to packed bytes plus count n) SHALL be a combinational sub-module, axis_keep_compress. The residue/output datapath uses a 2K-byte staging vector.

Verification (DATA_WIDTH=32, bytes shown lane0 first)
REQ-018 Beat tkeep 0101 data {11,xx,22,xx}, then beat tkeep 1111 {33,44,55,66} with tlast -> outputs tkeep 1111 {11,22,33,44}, then tkeep 0011 {55,66,00,00} with tlast.

REQ-019 Residue 3 bytes {A1,A2,A3}, then tlast beat tkeep 1111 {B1..B4} -> tkeep 1111 {A1,A2,A3,B1}, then tkeep 0111 {B2,B3,B4} with tlast; s_axis_tready is 0 for exactly the FLUSH cycle.

REQ-020 m_axis_tready held low 5 cycles with a full beat pending -> outputs stable, s_axis_tready=0, no byte lost or duplicated once ready returns.

REQ-021 Non-last beat with tkeep 0000 -> no output. Tlast beat with tkeep 0000 and R=0 -> one beat, tkeep 0000, tlast 1.

REQ-022 rst pulsed mid-frame with R=2 -> m_axis_tvalid 0 asynchronously. The next frame tkeep 1111 {C1..C4} with tlast -> exactly {C1..C4} with tlast, no stale bytes.

Source files
------------

// File: rtl/axis_keep_compress.sv
// Packs the kept byte lanes of one beat down to the low lanes (lane 0 first)
// and reports how many lanes were kept. Purely combinational.
module axis_keep_compress #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [DATA_WIDTH-1:0] packed_data,
    output logic [CNT_W-1:0]      count
);

    localparam int LANE_W = DATA_WIDTH / KEEP_WIDTH;

    // Dropped lanes never reach the output, so the unused upper lanes stay zero.
    always_comb begin
        int c;
        c           = 0;
        packed_data = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (keep[i]) begin
                packed_data[c*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
                c++;
            end
        end
        count = CNT_W'(c);
    end

endmodule

// File: rtl/axis_keep_packer.sv
// AXI-Stream tkeep packer: removes null bytes from sparse beats and repacks
// each frame into full beats, with only the final beat of a frame partial.
module axis_keep_packer #(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    localparam int K      = KEEP_WIDTH;
    localparam int LANE_W = DATA_WIDTH / K;
    localparam int CNT_W  = $clog2(K) + 1;
    localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);

    typedef enum logic {ACCUM, FLUSH} state_t;

    if (DATA_WIDTH % KEEP_WIDTH != 0) begin : g_width_check
        $error("axis_keep_packer: DATA_WIDTH must be divisible by KEEP_WIDTH");
    end

    function automatic logic [K-1:0] low_mask(input logic [CNT_W-1:0] cnt);
        for (int i = 0; i < K; i++) begin
            low_mask[i] = (CNT_W'(i) < cnt);
        end
    endfunction

    state_t                  state;
    logic [DATA_WIDTH-1:0]   res_data;
    logic [CNT_W-1:0]        res_cnt;
    logic [DATA_WIDTH-1:0]   packed_data;
    logic [CNT_W-1:0]        n_cnt;
    logic [CNT_W-1:0]        total;
    logic [K-1:0]            keep_eff;
    logic [2*DATA_WIDTH-1:0] stage;
    logic [DATA_WIDTH-1:0]   stage_lo;
    logic [DATA_WIDTH-1:0]   stage_hi;
    logic                    out_free;
    logic                    accept;
    logic                    emit;
    logic [ID_WIDTH-1:0]     id_in;
    logic [DEST_WIDTH-1:0]   dest_in;
    logic [USER_WIDTH-1:0]   user_in;

    assign keep_eff = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
    assign id_in    = (ID_ENABLE != 0)   ? s_axis_tid   : '0;
    assign dest_in  = (DEST_ENABLE != 0) ? s_axis_tdest : '0;
    assign user_in  = (USER_ENABLE != 0) ? s_axis_tuser : '0;

    axis_keep_compress #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (K),
        .CNT_W      (CNT_W)
    ) u_compress (
        .data        (s_axis_tdata),
        .keep        (keep_eff),
        .packed_data (packed_data),
        .count       (n_cnt)
    );

    // New bytes land directly above the residue in a 2K-lane staging vector;
    // residue lanes at or above res_cnt are always kept zero.
    always_comb begin
        stage = '0;
        for (int r = 0; r < K; r++) begin
            if (res_cnt == CNT_W'(r)) begin
                stage = {{DATA_WIDTH{1'b0}}, packed_data} << (r * LANE_W);
            end
        end
        stage = stage | {{DATA_WIDTH{1'b0}}, res_data};
    end

    assign stage_lo      = stage[DATA_WIDTH-1:0];
    assign stage_hi      = stage[2*DATA_WIDTH-1:DATA_WIDTH];
    assign total         = res_cnt + n_cnt;
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = !rst && out_free && (state == ACCUM);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign emit          = s_axis_tlast || (total >= K_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ACCUM;
            res_data      <= '0;
            res_cnt       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
            m_axis_tuser  <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (state == FLUSH) begin
                // Sideband registers keep the tlast input beat's values.
                if (out_free) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= res_data;
                    m_axis_tkeep  <= low_mask(res_cnt);
                    m_axis_tlast  <= 1'b1;
                    res_data      <= '0;
                    res_cnt       <= '0;
                    state         <= ACCUM;
                end
            end else if (accept) begin
                if (emit) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= stage_lo;
                    m_axis_tid    <= id_in;
                    m_axis_tdest  <= dest_in;
                    m_axis_tuser  <= user_in;
                    if (s_axis_tlast && (total <= K_CNT)) begin
                        m_axis_tkeep <= low_mask(total);
                        m_axis_tlast <= 1'b1;
                        res_data     <= '0;
                        res_cnt      <= '0;
                    end else begin
                        m_axis_tkeep <= '1;
                        m_axis_tlast <= 1'b0;
                        res_data     <= stage_hi;
                        res_cnt      <= total - K_CNT;
                        if (s_axis_tlast) begin
                            state <= FLUSH;
                        end
                    end
                end else begin
                    res_data <= stage_lo;
                    res_cnt  <= total;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_keep_packer.sv
// Directed bench for axis_keep_packer (DATA_WIDTH=32, lane 0 in bits [7:0]).
module tb_axis_keep_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [7:0]  s_axis_tid = '0;
    logic [7:0]  s_axis_tdest = '0;
    logic [0:0]  s_axis_tuser = '0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tid;
    logic [7:0]  m_axis_tdest;
    logic [0:0]  m_axis_tuser;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    beat_t q[$];

    always #5 clk = ~clk;

    axis_keep_packer #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser)
    );

    // Inputs change only just after rising edges, so the falling edge sees
    // exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser[0]});
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        logic got;
        int   waited;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        got    = 1'b0;
        waited = 0;
        while (!got && waited < 100) begin
            @(negedge clk);
            got = s_axis_tready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!got) check_val("send_timeout", 64'd0, 64'd1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int idx, input logic [31:0] d,
                             input logic [3:0] k, input logic l, input logic u);
        if (idx >= q.size()) begin
            check_val({tag, "_present"}, 64'(q.size()), 64'(idx + 1));
        end else begin
            check_val({tag, "_data"}, 64'(q[idx].d), 64'(d));
            check_val({tag, "_keep"}, 64'(q[idx].k), 64'(k));
            check_val({tag, "_last"}, 64'(q[idx].l), 64'(l));
            check_val({tag, "_user"}, 64'(q[idx].u), 64'(u));
        end
    endtask

    initial begin
        int low_cnt;

        // Reset state
        #1;
        check_val("rst_tready", 64'(s_axis_tready), 64'd0);
        check_val("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("post_rst_tready", 64'(s_axis_tready), 64'd1);
        check_val("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_val("post_rst_tdata",  64'(m_axis_tdata),  64'd0);
        check_val("post_rst_tkeep",  64'(m_axis_tkeep),  64'd0);
        check_val("post_rst_tlast",  64'(m_axis_tlast),  64'd0);
        check_val("post_rst_tid",    64'(m_axis_tid),    64'd0);
        check_val("post_rst_tdest",  64'(m_axis_tdest),  64'd0);
        check_val("post_rst_tuser",  64'(m_axis_tuser),  64'd0);
        @(posedge clk);
        #1;

        // Sparse beat then full tlast beat: overflow forces a flush beat
        q.delete();
        send(32'hEE22EE11, 4'b0101, 1'b0, 1'b0);
        send(32'h66554433, 4'b1111, 1'b1, 1'b1);
        drain();
        check_val("sparse_count", 64'(q.size()), 64'd2);
        check_out("sparse_b0", 0, 32'h44332211, 4'b1111, 1'b0, 1'b1);
        check_out("sparse_b1", 1, 32'h00006655, 4'b0011, 1'b1, 1'b1);

        // Residue of 3 then full tlast beat; tready low only during the flush cycle
        q.delete();
        send(32'hEEA3A2A1, 4'b0111, 1'b0, 1'b1);
        send(32'hB4B3B2B1, 4'b1111, 1'b1, 1'b0);
        low_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (!s_axis_tready) low_cnt++;
        end
        @(posedge clk);
        #1;
        check_val("flush_tready_low_cycles", 64'(low_cnt), 64'd1);
        drain();
        check_val("res3_count", 64'(q.size()), 64'd2);
        check_out("res3_b0", 0, 32'hB1A3A2A1, 4'b1111, 1'b0, 1'b0);
        check_out("res3_b1", 1, 32'h00B4B3B2, 4'b0111, 1'b1, 1'b0);

        // Backpressure: full beat held while downstream stalls for 5 cycles
        q.delete();
        m_axis_tready = 1'b0;
        send(32'hD4D3D2D1, 4'b1111, 1'b0, 1'b0);
        s_axis_tdata  = 32'hE4E3E2E1;
        s_axis_tkeep  = 4'b1111;
        s_axis_tlast  = 1'b1;
        s_axis_tuser  = 1'b1;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val($sformatf("stall%0d_tdata", c),  64'(m_axis_tdata),  64'hD4D3D2D1);
            check_val($sformatf("stall%0d_tvalid", c), 64'(m_axis_tvalid), 64'd1);
            check_val($sformatf("stall%0d_tready", c), 64'(s_axis_tready), 64'd0);
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        send(32'hE4E3E2E1, 4'b1111, 1'b1, 1'b1);
        drain();
        check_val("stall_count", 64'(q.size()), 64'd2);
        check_out("stall_b0", 0, 32'hD4D3D2D1, 4'b1111, 1'b0, 1'b0);
        check_out("stall_b1", 1, 32'hE4E3E2E1, 4'b1111, 1'b1, 1'b1);

        // Empty beats: non-last is swallowed, last yields a zero-keep beat
        q.delete();
        send(32'h12345678, 4'b0000, 1'b0, 1'b0);
        drain();
        check_val("empty_nonlast_count", 64'(q.size()), 64'd0);
        send(32'h9ABCDEF0, 4'b0000, 1'b1, 1'b0);
        drain();
        check_val("empty_last_count", 64'(q.size()), 64'd1);
        check_out("empty_last", 0, 32'h00000000, 4'b0000, 1'b1, 1'b0);

        // Asynchronous reset mid-frame with residue and a stalled output beat
        q.delete();
        m_axis_tready = 1'b0;
        send(32'hEEEE5B5A, 4'b0011, 1'b0, 1'b0);
        send(32'h4F3F2F1F, 4'b1111, 1'b0, 1'b0);
        check_val("prerst_tvalid", 64'(m_axis_tvalid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_val("async_rst_tready", 64'(s_axis_tready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_axis_tready = 1'b1;
        q.delete();
        send(32'hC4C3C2C1, 4'b1111, 1'b1, 1'b0);
        drain();
        check_val("after_rst_count", 64'(q.size()), 64'd1);
        check_out("after_rst", 0, 32'hC4C3C2C1, 4'b1111, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
